// File: rtl/hidden_layer_feeder_if.sv
// Frame-feeder bus: upstream sample stream in, parallel frame plus launch/complete
// handshake to the hidden layer, status out.
interface hidden_layer_feeder_if #(
    parameter int input_width = 5
);
    logic                          s_valid;
    logic signed [input_width-1:0] s_data;
    logic                          s_ready;
    logic signed [input_width-1:0] out0;
    logic signed [input_width-1:0] out1;
    logic signed [input_width-1:0] out2;
    logic signed [input_width-1:0] out3;
    logic                          input_ready;
    logic                          layer_ready;
    logic                          frame_done;
    logic                          timeout;
    logic                          err;
    logic [7:0]                    frames_done;

    modport master (
        output s_valid, s_data, layer_ready,
        input  s_ready, out0, out1, out2, out3, input_ready,
               frame_done, timeout, err, frames_done
    );

    modport slave (
        input  s_valid, s_data, layer_ready,
        output s_ready, out0, out1, out2, out3, input_ready,
               frame_done, timeout, err, frames_done
    );
endinterface

// File: rtl/hidden_layer_feeder.sv
// Packs serial signed samples into 4-sample frames for the hidden layer, with a
// shadow buffer so the next frame fills while the current one is computed.
//
// state  | meaning
// IDLE   | no frame in flight; launch as soon as the shadow buffer is full
// LAUNCH | frame just copied to out*; input_ready strobe, timer cleared
// WAIT   | waiting for a fresh rising edge of layer_ready, or timeout
module hidden_layer_feeder #(
    parameter int input_width    = 5,
    parameter int timeout_cycles = 64
) (
    input logic                   clk,
    input logic                   rst,
    hidden_layer_feeder_if.slave  bus
);
    localparam int timer_width = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [timer_width-1:0] timer_last = timer_width'(timeout_cycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } state_t;

    state_t                        state;
    logic signed [input_width-1:0] shadow [4];
    logic signed [input_width-1:0] active [4];
    logic [1:0]                    idx;
    logic                          shadow_full;
    logic                          layer_ready_q;
    logic [timer_width-1:0]        timer;
    logic                          err_q;
    logic [7:0]                    frames_done_q;

    logic ready_edge;
    logic accept;
    logic complete;
    logic expire;
    logic copy;

    // A level already high on WAIT entry leaves layer_ready_q set, so it never looks like an edge.
    assign ready_edge = bus.layer_ready & ~layer_ready_q;
    assign accept     = bus.s_valid & ~shadow_full;
    assign complete   = (state == WAIT) & ready_edge;
    assign expire     = (state == WAIT) & ~ready_edge & (timer == timer_last);
    assign copy       = shadow_full & ((state == IDLE) | complete);

    assign bus.s_ready     = ~shadow_full;
    assign bus.out0        = active[0];
    assign bus.out1        = active[1];
    assign bus.out2        = active[2];
    assign bus.out3        = active[3];
    assign bus.input_ready = (state == LAUNCH);
    assign bus.frame_done  = complete;
    assign bus.timeout     = expire;
    assign bus.err         = err_q;
    assign bus.frames_done = frames_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= 2'd0;
            shadow_full   <= 1'b0;
            layer_ready_q <= 1'b0;
            timer         <= '0;
            err_q         <= 1'b0;
            frames_done_q <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            layer_ready_q <= bus.layer_ready;

            if (accept) begin
                shadow[idx] <= bus.s_data;
                idx         <= idx + 2'd1;
                if (idx == 2'd3) begin
                    shadow_full <= 1'b1;
                end
            end

            // accept and copy are mutually exclusive: s_ready is low whenever a copy can occur
            if (copy) begin
                active      <= shadow;
                shadow_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (shadow_full) begin
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (ready_edge) begin
                        frames_done_q <= frames_done_q + 8'd1;
                        state         <= shadow_full ? LAUNCH : IDLE;
                    end else if (timer == timer_last) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hidden_layer_feeder.sv
// Directed bench for hidden_layer_feeder: frame launch timing, back-to-back frames,
// timeout, stale level, edge/timeout coincidence, mid-WAIT reset and counter wrap.
module tb_hidden_layer_feeder;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_mis = 0;

    hidden_layer_feeder_if #(.input_width(5)) bus ();

    hidden_layer_feeder #(
        .input_width   (5),
        .timeout_cycles(8)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d);
        int n = 0;
        while (!bus.s_ready && n < 32) begin
            tick();
            n++;
        end
        if (!bus.s_ready) chk("push_wait_s_ready", 0, 1);
        bus.s_valid = 1'b1;
        bus.s_data  = 5'(d);
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic complete_frame(input int seed);
        push(seed & 7);
        push(-(seed & 7));
        push(1);
        push(-1);
        tick();
        tick();
        bus.layer_ready = 1'b1;
        tick();
        bus.layer_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.layer_ready = 1'b0;
        tick();
        tick();

        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_input_ready", bus.input_ready, 0);
        chk("rst_out0", bus.out0, 0);
        chk("rst_out3", bus.out3, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_frames_done", bus.frames_done, 0);
        rst = 1'b0;

        // single frame
        push(3); push(-2); push(15); push(-16);
        chk("sf_s_ready_full", bus.s_ready, 0);
        chk("sf_no_launch_t1", bus.input_ready, 0);
        tick();
        chk("sf_launch_t2", bus.input_ready, 1);
        chk("sf_out0", bus.out0, 3);
        chk("sf_out1", bus.out1, -2);
        chk("sf_out2", bus.out2, 15);
        chk("sf_out3", bus.out3, -16);
        chk("sf_s_ready_back", bus.s_ready, 1);
        tick();
        chk("sf_strobe_width", bus.input_ready, 0);
        repeat (4) tick();
        bus.layer_ready = 1'b1;
        #1;
        chk("sf_frame_done", bus.frame_done, 1);
        chk("sf_no_timeout", bus.timeout, 0);
        tick();
        chk("sf_frame_done_pulse", bus.frame_done, 0);
        chk("sf_frames_done", bus.frames_done, 1);
        bus.layer_ready = 1'b0;

        // back-to-back
        push(10); push(11); push(12); push(13);
        tick();
        chk("bb_launch_a", bus.input_ready, 1);
        push(1); push(2); push(3); push(4);
        chk("bb_s_ready_full", bus.s_ready, 0);
        chk("bb_out0_held", bus.out0, 10);
        bus.layer_ready = 1'b1;
        #1;
        chk("bb_frame_done", bus.frame_done, 1);
        tick();
        chk("bb_launch_b", bus.input_ready, 1);
        chk("bb_out0", bus.out0, 1);
        chk("bb_out1", bus.out1, 2);
        chk("bb_out2", bus.out2, 3);
        chk("bb_out3", bus.out3, 4);
        chk("bb_s_ready_back", bus.s_ready, 1);
        chk("bb_frames_done", bus.frames_done, 2);
        tick();
        chk("bb_stale_no_done", bus.frame_done, 0);
        bus.layer_ready = 1'b0;
        tick();
        bus.layer_ready = 1'b1;
        #1;
        chk("bb_b_done", bus.frame_done, 1);
        tick();
        chk("bb_frames_done_b", bus.frames_done, 3);
        bus.layer_ready = 1'b0;

        // stale level across LAUNCH
        bus.layer_ready = 1'b1;
        push(5); push(6); push(7); push(8);
        tick();
        chk("st_launch", bus.input_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_no_done", bus.frame_done, 0);
        end
        bus.layer_ready = 1'b0;
        tick();
        bus.layer_ready = 1'b1;
        #1;
        chk("st_done", bus.frame_done, 1);
        tick();
        chk("st_frames_done", bus.frames_done, 4);
        bus.layer_ready = 1'b0;

        // timeout
        push(9); push(-9); push(0); push(1);
        tick();
        chk("to_launch", bus.input_ready, 1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("to_early", bus.timeout, 0);
        end
        tick();
        chk("to_pulse", bus.timeout, 1);
        chk("to_no_done", bus.frame_done, 0);
        tick();
        chk("to_pulse_width", bus.timeout, 0);
        chk("to_err", bus.err, 1);
        chk("to_frames_same", bus.frames_done, 4);
        chk("to_out0_kept", bus.out0, 9);
        chk("to_idle", bus.input_ready, 0);
        tick();
        chk("to_stay_idle", bus.input_ready, 0);

        // edge on the final timeout cycle
        push(7); push(-7); push(1); push(-1);
        tick();
        chk("co_launch", bus.input_ready, 1);
        repeat (8) tick();
        bus.layer_ready = 1'b1;
        #1;
        chk("co_frame_done", bus.frame_done, 1);
        chk("co_no_timeout", bus.timeout, 0);
        tick();
        chk("co_frames_done", bus.frames_done, 5);
        chk("co_err_sticky", bus.err, 1);
        chk("co_idle", bus.input_ready, 0);
        bus.layer_ready = 1'b0;

        // reset in WAIT with a partial shadow
        push(12); push(13); push(14); push(15);
        tick();
        tick();
        push(-8); push(-7);
        chk("rs_pre_s_ready", bus.s_ready, 1);
        rst = 1'b1;
        tick();
        chk("rs_out0", bus.out0, 0);
        chk("rs_out2", bus.out2, 0);
        chk("rs_input_ready", bus.input_ready, 0);
        chk("rs_s_ready", bus.s_ready, 1);
        chk("rs_frame_done", bus.frame_done, 0);
        chk("rs_timeout", bus.timeout, 0);
        chk("rs_err", bus.err, 0);
        chk("rs_frames_done", bus.frames_done, 0);
        rst = 1'b0;
        push(14); push(-3); push(-5); push(2);
        tick();
        chk("rs_launch", bus.input_ready, 1);
        chk("rs_new_out0", bus.out0, 14);
        chk("rs_new_out1", bus.out1, -3);
        chk("rs_new_out2", bus.out2, -5);
        chk("rs_new_out3", bus.out3, 2);
        tick();
        bus.layer_ready = 1'b1;
        tick();
        chk("rs_frames_done_1", bus.frames_done, 1);
        bus.layer_ready = 1'b0;

        // counter wrap
        for (int i = 0; i < 254; i++) complete_frame(i);
        chk("wr_255", bus.frames_done, 255);
        complete_frame(3);
        chk("wr_0", bus.frames_done, 0);
        chk("wr_err", bus.err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
